pipeline_rr_sched: RTL and testbench

- Round-robin scheduler that shares one fixed-latency, non-stallable register pipeline between N_REQ requesters.
- Issues at most one request per cycle into the pipeline's 4-bit input.
- Tracks each request's requester ID through a tag shadow pipeline of the same depth.
- Routes the pipeline output back to the originating requester; supports a drain sequence for quiescing before reconfiguration.

---
 rtl/pipeline_rr_sched.sv | 121 ++++++++++++
 tb/tb_pipeline_rr_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_rr_sched.sv
// ============================================================================
// Module      : pipeline_rr_sched
// Description : Round-robin scheduler sharing one fixed-latency pipeline
//               between N_REQ requesters, with requester-ID tag tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_rr_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int IDW   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   drain,
  output logic                   drained,
  output logic [WIDTH-1:0]       pipe_in,
  input  logic [WIDTH-1:0]       pipe_out,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [IDW-1:0]         resp_id,
  output logic                   busy
);

  localparam logic [IDW:0]   c_n_req   = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] c_last_id = IDW'(N_REQ - 1);

  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [DEPTH-1:0]          tag_v_q, tag_v_d;
  logic [DEPTH-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic           w_found;
  logic [IDW-1:0] w_grant_id;
  logic [IDW:0]   w_idx;
  logic           w_grant_any;
  logic           w_out_v;
  logic [IDW-1:0] w_out_id;

  // Search ptr, ptr+1, ... wrapping at N_REQ; the first valid requester wins.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (w_idx >= c_n_req) begin
        w_idx = w_idx - c_n_req;
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx[IDW-1:0];
      end
    end
  end

  // Reset gates the grant so nothing is accepted while the pipeline is cleared.
  assign w_grant_any = w_found & ~drain & ~reset;

  always_comb begin
    req_ready = '0;
    if (w_grant_any) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  assign pipe_in = w_grant_any ? req_data[w_grant_id*WIDTH +: WIDTH] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (w_grant_any) begin
      ptr_d = (w_grant_id == c_last_id) ? '0 : w_grant_id + 1'b1;
    end
  end

  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = w_grant_any;
    tag_id_d[0] = w_grant_any ? w_grant_id : '0;
    for (int s = 1; s < DEPTH; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  // The last tag stage lines up with pipe_out.
  assign w_out_v  = tag_v_q[DEPTH-1];
  assign w_out_id = tag_id_q[DEPTH-1];

  always_comb begin
    resp_valid = '0;
    if (w_out_v) begin
      resp_valid[w_out_id] = 1'b1;
    end
  end

  assign resp_id   = w_out_v ? w_out_id : '0;
  assign resp_data = pipe_out;
  assign busy      = |tag_v_q;
  assign drained   = drain & ~busy;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_rr_sched.sv
// ============================================================================
// Module      : tb_pipeline_rr_sched
// Description : Directed self-checking bench for pipeline_rr_sched with a
//               2-stage model of the shared pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_rr_sched;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        drain;
  logic        drained;
  logic [3:0]  pipe_in;
  logic [3:0]  pipe_out;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_data;
  logic [1:0]  resp_id;
  logic        busy;

  int vectors;
  int miscompares;

  logic [3:0] pipe_q [2];
  logic [3:0] e_rdy [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] e_pin [5] = '{4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
  logic [3:0] e_rv  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] e_rd  [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
  logic [1:0] e_rid [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
  int         cnt [4];

  pipeline_rr_sched #(
    .N_REQ(4), .WIDTH(4), .DEPTH(2), .IDW(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .drain      (drain),
    .drained    (drained),
    .pipe_in    (pipe_in),
    .pipe_out   (pipe_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Shared pipeline, reset by the same signal as the scheduler.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_q[0] <= '0;
      pipe_q[1] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      pipe_q[1] <= pipe_q[0];
    end
  end
  assign pipe_out = pipe_q[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] e;
    int         id;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    reset     = 1'b1;
    drain     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 16'h4321;

    // Reset state with all requesters valid
    @(negedge clock); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pipe_in", 32'(pipe_in), 32'h0);
    chk("rst_drained0", 32'(drained), 32'h0);
    drain = 1'b1; #1;
    chk("rst_drained1", 32'(drained), 32'h1);
    drain = 1'b0;
    reset = 1'b0; #1;
    chk("rr_ready0", 32'(req_ready), 32'b0001);
    chk("rr_pipe_in0", 32'(pipe_in), 32'h1);

    for (int k = 1; k <= 5; k++) begin
      @(negedge clock); #1;
      chk("rr_ready", 32'(req_ready), 32'(e_rdy[k-1]));
      chk("rr_pipe_in", 32'(pipe_in), 32'(e_pin[k-1]));
      chk("rr_resp_valid", 32'(resp_valid), 32'(e_rv[k-1]));
      if (k >= 2) begin
        chk("rr_resp_data", 32'(resp_data), 32'(e_rd[k-1]));
        chk("rr_resp_id", 32'(resp_id), 32'(e_rid[k-1]));
      end
    end

    @(negedge clock); req_valid = 4'b0000; #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("idle_pipe_in", 32'(pipe_in), 32'h0);
    chk("idle_resp_valid0", 32'(resp_valid), 32'b0001);
    chk("idle_resp_data0", 32'(resp_data), 32'h1);
    chk("idle_busy0", 32'(busy), 32'h1);
    @(negedge clock); #1;
    chk("idle_resp_valid1", 32'(resp_valid), 32'b0010);
    chk("idle_resp_id1", 32'(resp_id), 32'h1);
    @(negedge clock); #1;
    chk("idle_resp_valid2", 32'(resp_valid), 32'b0000);
    chk("idle_busy2", 32'(busy), 32'h0);

    // Single requester (2) valid, ptr starts at 2 then sits at 3
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      req_valid = (j < 5) ? 4'b0100 : 4'b0000;
      req_data  = 16'h0A00;
      #1;
      chk("single_ready", 32'(req_ready), (j < 5) ? 32'b0100 : 32'h0);
      chk("single_pipe_in", 32'(pipe_in), (j < 5) ? 32'hA : 32'h0);
      if (j >= 2 && j <= 6) begin
        chk("single_resp_valid", 32'(resp_valid), 32'b0100);
        chk("single_resp_data", 32'(resp_data), 32'hA);
        chk("single_resp_id", 32'(resp_id), 32'h2);
      end else begin
        chk("single_resp_valid0", 32'(resp_valid), 32'h0);
        chk("single_resp_id0", 32'(resp_id), 32'h0);
      end
    end

    // ptr=3 with requesters 0 and 3 valid
    @(negedge clock); req_valid = 4'b1001; req_data = 16'hC005; #1;
    chk("wrap_ready3", 32'(req_ready), 32'b1000);
    chk("wrap_pipe_in3", 32'(pipe_in), 32'hC);
    @(negedge clock); #1;
    chk("wrap_ready0", 32'(req_ready), 32'b0001);
    chk("wrap_pipe_in0", 32'(pipe_in), 32'h5);
    @(negedge clock); #1;
    chk("wrap_ready3b", 32'(req_ready), 32'b1000);
    @(negedge clock); req_valid = 4'b0000; #1;
    chk("drop_ready", 32'(req_ready), 32'h0);
    @(negedge clock); req_valid = 4'b1111; #1;
    chk("drop_hold_ptr", 32'(req_ready), 32'b0001);
    @(negedge clock); req_valid = 4'b0000; #1;
    @(negedge clock); #1;
    chk("drop_resp_valid", 32'(resp_valid), 32'b0001);
    chk("drop_resp_data", 32'(resp_data), 32'h5);
    @(negedge clock); #1;
    chk("drop_busy", 32'(busy), 32'h0);

    // Drain under continuous traffic, ptr=1
    req_data = 16'h4321;
    @(negedge clock); req_valid = 4'b1111; #1;
    chk("drn_c0", 32'(req_ready), 32'b0010);
    @(negedge clock); #1;
    chk("drn_c1", 32'(req_ready), 32'b0100);
    @(negedge clock); #1;
    chk("drn_c2", 32'(req_ready), 32'b1000);
    @(negedge clock); #1;
    chk("drn_c3", 32'(req_ready), 32'b0001);
    @(negedge clock); drain = 1'b1; #1;
    chk("drn_c4_ready", 32'(req_ready), 32'h0);
    chk("drn_c4_pipe_in", 32'(pipe_in), 32'h0);
    chk("drn_c4_busy", 32'(busy), 32'h1);
    chk("drn_c4_drained", 32'(drained), 32'h0);
    chk("drn_c4_resp_valid", 32'(resp_valid), 32'b1000);
    chk("drn_c4_resp_data", 32'(resp_data), 32'h4);
    @(negedge clock); #1;
    chk("drn_c5_busy", 32'(busy), 32'h1);
    chk("drn_c5_drained", 32'(drained), 32'h0);
    chk("drn_c5_resp_valid", 32'(resp_valid), 32'b0001);
    @(negedge clock); #1;
    chk("drn_c6_busy", 32'(busy), 32'h0);
    chk("drn_c6_drained", 32'(drained), 32'h1);
    chk("drn_c6_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clock); #1;
    chk("drn_c7_drained", 32'(drained), 32'h1);
    chk("drn_c7_ready", 32'(req_ready), 32'h0);
    @(negedge clock); drain = 1'b0; #1;
    chk("drn_release_ready", 32'(req_ready), 32'b0010);
    chk("drn_release_drained", 32'(drained), 32'h0);
    @(negedge clock); req_valid = 4'b0000; #1;
    chk("drn_c9_ready", 32'(req_ready), 32'h0);
    @(negedge clock); req_valid = 4'b1111; drain = 1'b1; #1;
    chk("drn_rise_ready", 32'(req_ready), 32'h0);
    chk("drn_rise_busy", 32'(busy), 32'h1);
    chk("drn_rise_drained", 32'(drained), 32'h0);
    @(negedge clock); #1;
    chk("drn_c11_busy", 32'(busy), 32'h0);
    chk("drn_c11_drained", 32'(drained), 32'h1);

    // Reset with requests in flight, ptr=2
    @(negedge clock); drain = 1'b0; #1;
    chk("mrst_c0", 32'(req_ready), 32'b0100);
    @(negedge clock); #1;
    chk("mrst_c1", 32'(req_ready), 32'b1000);
    @(negedge clock); #1;
    chk("mrst_c2_ready", 32'(req_ready), 32'b0001);
    chk("mrst_c2_resp_valid", 32'(resp_valid), 32'b0100);
    chk("mrst_c2_resp_data", 32'(resp_data), 32'h3);
    chk("mrst_c2_busy", 32'(busy), 32'h1);
    reset = 1'b1; #1;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mrst_resp_id", 32'(resp_id), 32'h0);
    chk("mrst_ready", 32'(req_ready), 32'h0);
    chk("mrst_pipe_in", 32'(pipe_in), 32'h0);
    @(negedge clock); reset = 1'b0; #1;
    chk("mrst_ptr0", 32'(req_ready), 32'b0001);
    chk("mrst_c3_resp_valid", 32'(resp_valid), 32'h0);
    chk("mrst_c3_busy", 32'(busy), 32'h0);
    @(negedge clock); #1;
    chk("mrst_c4_ready", 32'(req_ready), 32'b0010);
    chk("mrst_c4_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clock); req_valid = 4'b0000; #1;
    chk("mrst_c5_resp_valid", 32'(resp_valid), 32'b0001);

    // Full contention: requester i sends i+5, from ptr=0
    @(negedge clock); reset = 1'b1;
    for (int k = 0; k < 42; k++) begin
      @(negedge clock);
      reset     = 1'b0;
      req_valid = (k < 40) ? 4'b1111 : 4'b0000;
      req_data  = 16'h8765;
      #1;
      e = (k < 40) ? (4'b0001 << (k % 4)) : 4'b0000;
      chk("cont_ready", 32'(req_ready), 32'(e));
      for (int i = 0; i < 4; i++) begin
        if (resp_valid[i]) cnt[i]++;
      end
      if (k >= 2) begin
        id = (k - 2) % 4;
        e  = 4'b0001 << id;
        chk("cont_resp_valid", 32'(resp_valid), 32'(e));
        chk("cont_resp_id", 32'(resp_id), 32'(id));
        chk("cont_resp_data", 32'(resp_data), 32'(id + 5));
      end else begin
        chk("cont_resp_valid0", 32'(resp_valid), 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk("cont_count", 32'(cnt[i]), 32'd10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
